led_scan_controller: RTL and testbench

LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

---
 rtl/led_scan_controller.sv | 152 +++++++++++++++
 tb/tb_led_scan_controller.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// ============================================================================
// led_scan_controller
// ----------------------------------------------------------------------------
// Column-scanned LED matrix controller for a double-buffered N x N cell frame.
// Each column is blanked for BLANK cycles (ena=0), then driven for DWELL
// cycles (ena=1). The column index x advances only at the end of a drive, so
// x is stable for the whole time ena is high. New frames are accepted into a
// single pending register and promoted to the displayed frame (cells) only at
// the frame boundary, which is the end of the drive of column N-1. A displayed
// frame therefore always covers every column exactly once per scan.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   frame_in     N*N-bit cell frame offered for display
//   frame_valid  frame_in holds a frame
//   frame_ready  a frame can be accepted this cycle (0 while rst is high)
//   ena          registered column-decoder enable
//   x            registered column index, $clog2(N)+1 bits
//   cells        registered frame currently displayed
//   frame_start  registered one-cycle pulse on the first drive cycle of col 0
// ============================================================================
module led_scan_controller #(
    parameter int N     = 8,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*N-1:0]       frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 ena,
    output logic [$clog2(N):0]   x,
    output logic [N*N-1:0]       cells,
    output logic                 frame_start
);

    localparam int XW      = $clog2(N) + 1;
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    initial begin
        if (N < 1 || N > 8)
            $error("led_scan_controller: N=%0d outside 1..8", N);
        if (DWELL < 1)
            $error("led_scan_controller: DWELL=%0d must be at least 1", DWELL);
        if (BLANK < 1)
            $error("led_scan_controller: BLANK=%0d must be at least 1", BLANK);
    end

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [XW-1:0]     x_d;
    logic              blank_done, drive_done;

    logic              ena_d, frame_start_d;
    logic [N*N-1:0]    cells_d, pending, pending_d;
    logic              pending_full, pending_full_d;
    logic              accept, swap;

    // Ready is gated by rst so nothing upstream sees a handshake while the
    // buffers are being cleared.
    assign frame_ready = !pending_full && !rst;
    assign accept      = frame_valid && frame_ready;

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs and buffers)
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_BLANK;
            cnt          <= '0;
            x            <= '0;
            ena          <= 1'b0;
            frame_start  <= 1'b0;
            cells        <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            x            <= x_d;
            ena          <= ena_d;
            frame_start  <= frame_start_d;
            cells        <= cells_d;
            pending      <= pending_d;
            pending_full <= pending_full_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: one counter times both phases
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 1'b1;
        x_d        = x;
        blank_done = 1'b0;
        drive_done = 1'b0;
        case (state)
            S_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_d    = S_DRIVE;
                    cnt_d      = '0;
                    blank_done = 1'b1;
                end
            end
            S_DRIVE: begin
                if (cnt == DWELL_LAST) begin
                    state_d    = S_BLANK;
                    cnt_d      = '0;
                    drive_done = 1'b1;
                    x_d        = (x == X_LAST) ? '0 : x + 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs and buffers
    // ------------------------------------------------------------------
    always_comb begin
        // The swap looks at pending_full as registered; a frame accepted on
        // this same edge waits for the following frame boundary. Accept and
        // swap are mutually exclusive because accept needs pending_full low.
        swap           = drive_done && (x == X_LAST) && pending_full;
        ena_d          = (state_d == S_DRIVE);
        frame_start_d  = blank_done && (x == '0);
        cells_d        = swap ? pending : cells;
        pending_d      = accept ? frame_in : pending;
        pending_full_d = pending_full;
        if (swap)
            pending_full_d = 1'b0;
        if (accept)
            pending_full_d = 1'b1;
    end

endmodule

// File: tb/tb_led_scan_controller.sv
// ============================================================================
// tb_led_scan_controller
// ----------------------------------------------------------------------------
// Self-checking bench for led_scan_controller with N=8, DWELL=4, BLANK=2.
// The reference model tracks only the number of clock edges k since reset
// release plus a pending/displayed frame pair. Scan outputs are derived from
// k by plain arithmetic (position within a 48-cycle frame), and frames swap
// on every edge where k becomes a multiple of the frame period.
// ============================================================================
module tb_led_scan_controller;

    localparam int N     = 8;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int COL   = BLANK + DWELL;
    localparam int P     = N * COL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic        ena;
    logic [3:0]  x;
    logic [63:0] cells;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          k = 0;
    logic [63:0] m_cells = '0;
    logic [63:0] m_pend  = '0;
    bit          m_pend_full = 1'b0;

    led_scan_controller #(.N(N), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .ena         (ena),
        .x           (x),
        .cells       (cells),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ena();
        return ((k % P) % COL) >= BLANK;
    endfunction

    function automatic logic [3:0] exp_x();
        return 4'((k % P) / COL);
    endfunction

    function automatic bit exp_fs();
        return (k % P) == BLANK;
    endfunction

    function automatic bit exp_ready();
        return !m_pend_full && !rst;
    endfunction

    function automatic void model_reset();
        k           = 0;
        m_cells     = '0;
        m_pend      = '0;
        m_pend_full = 1'b0;
    endfunction

    // Advance one clock edge, update the model from the pre-edge inputs,
    // and leave time 1 unit after the edge for sampling.
    task automatic tick();
        bit boundary;
        bit acc;
        @(posedge clk);
        if (!rst) begin
            boundary = ((k + 1) % P) == 0;
            acc      = frame_valid && !m_pend_full;
            if (boundary && m_pend_full) begin
                m_cells     = m_pend;
                m_pend_full = 1'b0;
            end
            if (acc) begin
                m_pend      = frame_in;
                m_pend_full = 1'b1;
            end
            k++;
        end
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst         = 1'b1;
        frame_valid = 1'b1;
        frame_in    = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ena, x, frame_start, frame_ready} !== 7'b0 || cells !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: ena=%b x=%0d fs=%b ready=%b cells=%h, all should be 0",
                     ena, x, frame_start, frame_ready, cells);
        end
        frame_valid = 1'b0;
        rst         = 1'b0;
        model_reset();
        #1;
        checks++;
        if (frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", frame_ready);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scan_timing();
        int fs_times[$];
        for (int i = 0; i < 2 * P + 8; i++) begin
            tick();
            checks++;
            if (ena !== exp_ena() || x !== exp_x() || frame_start !== exp_fs()) begin
                errors++;
                $display("FAIL scan_k%0d: ena=%b x=%0d fs=%b, expected ena=%b x=%0d fs=%b",
                         k, ena, x, frame_start, exp_ena(), exp_x(), exp_fs());
            end
            checks++;
            if (cells !== 64'h0 || frame_ready !== 1'b1) begin
                errors++;
                $display("FAIL scan_idle_k%0d: cells=%h ready=%b, expected 0 and 1",
                         k, cells, frame_ready);
            end
            if (frame_start === 1'b1) fs_times.push_back(k);
        end
        checks++;
        if (fs_times.size() != 3 || fs_times[0] != BLANK) begin
            errors++;
            $display("FAIL frame_start_count: got %0d pulses, expected 3 with first at edge %0d",
                     fs_times.size(), BLANK);
        end else begin
            for (int i = 1; i < fs_times.size(); i++) begin
                checks++;
                if (fs_times[i] - fs_times[i-1] != P) begin
                    errors++;
                    $display("FAIL frame_start_period: got %0d expected %0d",
                             fs_times[i] - fs_times[i-1], P);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_frame();
        logic [63:0] f;
        logic [63:0] old;
        bit          done;
        f    = 64'h0123456789ABCDEF;
        old  = cells;
        done = 1'b0;
        for (int i = 0; i < P && (k % P) != 20; i++) tick();
        frame_in    = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        checks++;
        if (frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_drop: got %b expected 0", frame_ready);
        end
        for (int i = 0; i <= P && !done; i++) begin
            tick();
            checks++;
            if ((k % P) != 0) begin
                if (cells !== old || frame_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL single_hold_k%0d: cells=%h ready=%b, expected %h and 0",
                             k, cells, frame_ready, old);
                end
            end else begin
                done = 1'b1;
                if (cells !== f || frame_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_swap: cells=%h ready=%b, expected %h and 1",
                             cells, frame_ready, f);
                end
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL single_timeout: no frame boundary within %0d cycles", P + 1);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [63:0] a, b;
        bit          ready_before;
        bit          b_taken;
        int          k_a, k_b;
        a       = {$urandom, $urandom};
        b       = {$urandom, $urandom} ^ 64'h1;
        b_taken = 1'b0;
        k_a     = -1;
        k_b     = -1;
        for (int i = 0; i < 5; i++) tick();
        frame_in    = a;
        frame_valid = 1'b1;
        tick();
        frame_in = b;
        for (int i = 0; i < 2 * P && !b_taken; i++) begin
            ready_before = frame_ready;
            tick();
            if (cells === a && k_a < 0) k_a = k;
            checks++;
            if (frame_ready !== exp_ready() || cells !== m_cells) begin
                errors++;
                $display("FAIL b2b_stall_k%0d: ready=%b cells=%h, expected %b %h",
                         k, frame_ready, cells, exp_ready(), m_cells);
            end
            if (ready_before) begin
                b_taken     = 1'b1;
                frame_valid = 1'b0;
            end
        end
        checks++;
        if (!b_taken || (k % P) != 1) begin
            errors++;
            $display("FAIL b2b_accept_b: taken=%b at frame position %0d, expected 1 at 1",
                     b_taken, k % P);
        end
        for (int i = 0; i < 2 * P && k_b < 0; i++) begin
            tick();
            if (cells === b) k_b = k;
        end
        checks++;
        if (k_a < 0 || k_b - k_a != P) begin
            errors++;
            $display("FAIL b2b_a_duration: A shown %0d cycles, expected %0d", k_b - k_a, P);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_swap_cycle_accept();
        logic [63:0] c, shown;
        int          k_acc, k_c;
        c     = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        shown = cells;
        k_c   = -1;
        for (int i = 0; i < P && (k % P) != P - 1; i++) tick();
        frame_in    = c;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        k_acc       = k;
        checks++;
        if (cells !== shown || frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL swapcyc_hold: cells=%h ready=%b, expected %h and 0",
                     cells, frame_ready, shown);
        end
        for (int i = 0; i < 2 * P && k_c < 0; i++) begin
            tick();
            if (cells === c) k_c = k;
        end
        checks++;
        if (k_c - k_acc != P) begin
            errors++;
            $display("FAIL swapcyc_delay: new frame shown %0d cycles after accept, expected %0d",
                     k_c - k_acc, P);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        bit          prev_ena;
        logic [3:0]  prev_x;
        logic [63:0] prev_cells;
        prev_ena   = ena;
        prev_x     = x;
        prev_cells = cells;
        for (int i = 0; i < 400; i++) begin
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_in    = {$urandom, $urandom};
            tick();
            checks++;
            if (ena !== exp_ena() || x !== exp_x() || frame_start !== exp_fs() ||
                cells !== m_cells || frame_ready !== exp_ready()) begin
                errors++;
                $display("FAIL random_k%0d: ena=%b x=%0d fs=%b ready=%b cells=%h, expected %b %0d %b %b %h",
                         k, ena, x, frame_start, frame_ready, cells,
                         exp_ena(), exp_x(), exp_fs(), exp_ready(), m_cells);
            end
            checks++;
            if ((prev_ena && ena === 1'b1 && x !== prev_x) ||
                (cells !== prev_cells && (k % P) != 0)) begin
                errors++;
                $display("FAIL invariant_k%0d: x %0d->%0d cells %h->%h",
                         k, prev_x, x, prev_cells, cells);
            end
            prev_ena   = (ena === 1'b1);
            prev_x     = x;
            prev_cells = cells;
        end
        frame_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_column();
        logic [63:0] e;
        e = {$urandom, $urandom} | 64'h1;
        for (int i = 0; i < P && (k % P) != 3; i++) tick();
        if (m_pend_full) begin
            // Let any frame already pending from the random phase swap in.
            for (int i = 0; i < P && (k % P) != 3 + COL; i++) tick();
        end
        frame_in    = e;
        frame_valid = !m_pend_full;
        tick();
        frame_valid = 1'b0;
        for (int i = 0; i < P && (k % P) != 5 * COL + BLANK + 1; i++) tick();
        checks++;
        if (ena !== 1'b1 || x !== 4'd5 || frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_setup: ena=%b x=%0d ready=%b, expected 1 5 0",
                     ena, x, frame_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ena, x, frame_start, frame_ready} !== 7'b0 || cells !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_async: ena=%b x=%0d fs=%b ready=%b cells=%h, all should be 0",
                     ena, x, frame_start, frame_ready, cells);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < P + COL; i++) begin
            tick();
            checks++;
            if (ena !== exp_ena() || x !== exp_x() || frame_start !== exp_fs() ||
                cells !== 64'h0 || frame_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_after_k%0d: ena=%b x=%0d fs=%b ready=%b cells=%h, expected %b %0d %b 1 0",
                         k, ena, x, frame_start, frame_ready, cells,
                         exp_ena(), exp_x(), exp_fs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_single_frame();
        test_back_to_back();
        test_swap_cycle_accept();
        test_random();
        test_reset_mid_column();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
